// File: rtl/cyclic_lamp_pkg.sv
// Shared encodings for the cyclic lamp scheduler: FSM states and lamp drive patterns.
package cyclic_lamp_pkg;

  typedef enum logic [1:0] {
    S_RED = 2'd0,
    S_GRN = 2'd1,
    S_YEL = 2'd2,
    S_FLS = 2'd3
  } state_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  // Lamp pattern for a state; in FLASH only the yellow lamp follows blink.
  function automatic logic [2:0] lamp_of(input state_e s, input logic blink);
    logic [2:0] l;
    l = L_OFF;
    case (s)
      S_RED:   l = L_RED;
      S_GRN:   l = L_GRN;
      S_YEL:   l = L_YEL;
      S_FLS:   l = blink ? L_YEL : L_OFF;
      default: l = L_OFF;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cyclic_lamp_ctrl_dwell.sv
// Dwell counter: counts cycles since the last clear and flags the final cycle of a D-cycle interval.
module lamp_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] d,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == d - {{(CNT_W-1){1'b0}}, 1'b1});
  assign cnt  = cnt_q;

endmodule

// File: rtl/cyclic_lamp_ctrl.sv
// Three-lamp phase scheduler: RED -> GREEN -> YELLOW cycling, request-shortened GREEN,
// and a yellow flash maintenance mode while en is low.
module cyclic_lamp_ctrl
  import cyclic_lamp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RED_T   = 10,
  parameter int GRN_T   = 8,
  parameter int GRN_MIN = 2,
  parameter int YEL_T   = 3,
  parameter int BLINK_T = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req,
  output logic       ack,
  output logic [2:0] light,
  output logic [1:0] phase
);

  localparam logic [CNT_W-1:0] RED_D  = CNT_W'(RED_T);
  localparam logic [CNT_W-1:0] GRN_D  = CNT_W'(GRN_T);
  localparam logic [CNT_W-1:0] YEL_D  = CNT_W'(YEL_T);
  localparam logic [CNT_W-1:0] BLK_D  = CNT_W'(BLINK_T);
  localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(GRN_MIN - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             blink_q, blink_d;
  logic [2:0]       light_q, light_d;
  logic [1:0]       phase_q, phase_d;
  logic             clr;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dwell;

  // One counter serves every state; its interval follows the current state.
  always_comb begin
    dwell = RED_D;
    case (state_q)
      S_RED:   dwell = RED_D;
      S_GRN:   dwell = GRN_D;
      S_YEL:   dwell = YEL_D;
      S_FLS:   dwell = BLK_D;
      default: dwell = RED_D;
    endcase
  end

  lamp_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .d    (dwell),
    .done (done),
    .cnt  (cnt)
  );

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    pend_d  = pend_q | req;
    ack_d   = 1'b0;
    clr     = 1'b0;
    if (!en) begin
      // Flash overrides every phase exit; counter restarts on entry and at each half-period.
      state_d = S_FLS;
      if (state_q != S_FLS) begin
        clr     = 1'b1;
        blink_d = 1'b1;
      end else if (done) begin
        clr     = 1'b1;
        blink_d = ~blink_q;
      end
    end else begin
      case (state_q)
        S_RED: if (done) begin
          state_d = S_GRN;
          clr     = 1'b1;
        end
        S_GRN: if (done || (pend_q && cnt >= GMIN_L)) begin
          state_d = S_YEL;
          clr     = 1'b1;
        end
        S_YEL: if (done) begin
          state_d = S_RED;
          clr     = 1'b1;
          // Serving a request; a request on this very edge stays pending.
          if (pend_q) begin
            ack_d  = 1'b1;
            pend_d = req;
          end
        end
        S_FLS: begin
          state_d = S_RED;
          clr     = 1'b1;
          blink_d = 1'b0;
        end
        default: begin
          state_d = S_RED;
          clr     = 1'b1;
        end
      endcase
    end
    light_d = lamp_of(state_d, blink_d);
    phase_d = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RED;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      blink_q <= 1'b0;
      light_q <= L_RED;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      blink_q <= blink_d;
      light_q <= light_d;
      phase_q <= phase_d;
    end
  end

  assign ack   = ack_q;
  assign light = light_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_cyclic_lamp_ctrl.sv
// Randomized and directed bench for cyclic_lamp_ctrl with a queue-based scoreboard.
module tb_cyclic_lamp_ctrl;

  localparam int RED_T   = 10;
  localparam int GRN_T   = 8;
  localparam int GRN_MIN = 2;
  localparam int YEL_T   = 3;
  localparam int BLINK_T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       req = 1'b0;
  logic       ack;
  logic [2:0] light;
  logic [1:0] phase;

  int n_pass  = 0;
  int n_total = 0;

  logic [5:0] exp_q[$];
  bit         primed = 0;

  // Reference model state: phase index, cycles completed in it, request flag, flash age.
  int m_ph   = 0;
  int m_age  = 0;
  bit m_pend = 0;
  int m_fage = 0;

  cyclic_lamp_ctrl #(
    .CNT_W(8), .RED_T(RED_T), .GRN_T(GRN_T), .GRN_MIN(GRN_MIN),
    .YEL_T(YEL_T), .BLINK_T(BLINK_T)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .ack(ack), .light(light), .phase(phase)
  );

  initial forever #5 clk = ~clk;

  function automatic int dwell_of(input int ph);
    case (ph)
      0: return RED_T;
      1: return GRN_T;
      default: return YEL_T;
    endcase
  endfunction

  function automatic logic [2:0] lamp_exp(input int ph, input int fage);
    case (ph)
      0: return 3'b100;
      1: return 3'b001;
      2: return 3'b010;
      default: return (((fage / BLINK_T) % 2) == 0) ? 3'b010 : 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got ack/phase/light=%b required %b", name, $time, act, exp);
  endtask

  // Model: advances one clock per edge from the behavioural rules and queues the outcome.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = 0; m_age = 0; m_pend = 0; m_fage = 0;
      exp_q.delete();
      primed = 0;
    end else begin
      bit m_ack;
      int elapsed;
      bit leave;
      m_ack = 0;
      if (!en) begin
        if (m_ph != 3) m_fage = 0;
        else m_fage++;
        m_ph = 3;
        m_pend = m_pend | req;
      end else if (m_ph == 3) begin
        m_ph = 0; m_age = 0;
        m_pend = m_pend | req;
      end else begin
        elapsed = m_age + 1;
        leave = (elapsed >= dwell_of(m_ph)) ||
                (m_ph == 1 && m_pend && elapsed >= GRN_MIN);
        if (leave) begin
          if (m_ph == 2 && m_pend) begin
            m_ack = 1;
            m_pend = req;
          end else begin
            m_pend = m_pend | req;
          end
          m_ph = (m_ph + 1) % 3;
          m_age = 0;
        end else begin
          m_pend = m_pend | req;
          m_age = elapsed;
        end
      end
      exp_q.push_back({m_ack, 2'(m_ph), lamp_exp(m_ph, m_fage)});
      primed = 1;
    end
  end

  // Monitor: one registered output set per cycle, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (exp_q.size() > 0) begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("cycle", {ack, phase, light}, e);
      end else if (primed) begin
        n_total++;
        $display("FAIL scoreboard_underflow at %0t: got no expectation, required one", $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_phase(input logic [1:0] p, input int maxc);
    int k;
    k = 0;
    while (phase !== p && k < maxc) begin
      cyc();
      k++;
    end
    if (phase !== p) begin
      n_total++;
      $display("FAIL wait_phase: got phase %0d required %0d within %0d cycles", phase, p, maxc);
    end
  endtask

  // Asynchronous reset in mid-cycle; outputs must return before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset", {ack, phase, light}, 6'b0_00_100);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_state", {ack, phase, light}, 6'b0_00_100);
    rst = 1'b0;

    run(50);

    wait_phase(2'd1, 40);
    req = 1'b1; cyc(); req = 1'b0;
    run(30);

    wait_phase(2'd0, 40);
    run(4);
    req = 1'b1; cyc(); req = 1'b0;
    run(40);

    wait_phase(2'd2, 40);
    cyc();
    en = 1'b0; run(12);
    en = 1'b1; run(25);

    wait_phase(2'd0, 40);
    req = 1'b1; cyc(); req = 1'b0;
    wait_phase(2'd1, 40);
    cyc();
    async_reset();
    run(30);

    req = 1'b1; run(60); req = 1'b0;
    run(10);

    for (int i = 0; i < 900; i++) begin
      req = ($urandom_range(0, 7) == 0);
      if (en && $urandom_range(0, 59) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end
    en = 1'b1; req = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
